// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the per-width byte-lane mask.
package lsu_pkg;

  localparam logic [2:0] Func3Byte  = 3'b000;
  localparam logic [2:0] Func3Half  = 3'b001;
  localparam logic [2:0] Func3Word  = 3'b010;
  localparam logic [2:0] Func3ByteU = 3'b100;
  localparam logic [2:0] Func3HalfU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StResp
  } state_e;

  // Lanes covered by an aligned access of the given width; 0 marks an undefined code.
  function automatic logic [3:0] width_mask(input logic [2:0] func3);
    logic [3:0] mask;
    case (func3)
      Func3Byte, Func3ByteU: mask = 4'b0001;
      Func3Half, Func3HalfU: mask = 4'b0011;
      Func3Word:             mask = 4'b1111;
      default:               mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ld_extend.sv
// Load data alignment: shifts the (possibly two-beat) read data down to the
// access offset and sign- or zero-extends it according to func3.
module ld_extend
  import lsu_pkg::*;
(
  input  logic [63:0] beat_data,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Right-justify the addressed bytes, then extend to 32 bits.
  always_comb begin
    shifted = 32'(beat_data >> {offset, 3'b000});
    case (func3)
      Func3Byte:  result = {{24{shifted[7]}}, shifted[7:0]};
      Func3Half:  result = {{16{shifted[15]}}, shifted[15:0]};
      Func3ByteU: result = {24'h0, shifted[7:0]};
      Func3HalfU: result = {16'h0, shifted[15:0]};
      default:    result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller for an RV32I pipeline. Accepts one access,
// drives a word-wide memory port with lane enables and returns extended load
// data with a one-cycle completion pulse.
// Build option LSU_MISALIGN_SPLIT_EN: misaligned accesses are split into two
// word beats; without it they complete immediately with rsp_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [2:0]        func3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-3:0] word_q;
  logic [7:0]        be_q;
  logic [63:0]       wdata_q;
  logic              err_q;
  logic [31:0]       data0_q, data1_q;
  logic [31:0]       ext_data;

  logic       accept;
  logic [1:0] off;
  logic [3:0] mask;
  logic       invalid, misaligned, acc_err;
  logic       split;    // access in flight needs a second beat
  logic       beat_hi;  // currently presenting the second beat

`ifdef LSU_MISALIGN_SPLIT_EN
  logic split_q;
  logic acc_split;
  assign split   = split_q;
  assign beat_hi = (state_q == StReq1);
`else
  assign split   = 1'b0;
  assign beat_hi = 1'b0;
`endif

  assign accept = req_valid && (state_q == StIdle);

  // Classify the incoming request.
  always_comb begin
    off        = req_addr[1:0];
    mask       = width_mask(req_func3);
    invalid    = (mask == 4'b0000) ||
                 (req_we && ((req_func3 == Func3ByteU) || (req_func3 == Func3HalfU)));
    misaligned = ((mask == 4'b0011) && (off == 2'd3)) ||
                 ((mask == 4'b1111) && (off != 2'd0));
`ifdef LSU_MISALIGN_SPLIT_EN
    acc_err   = invalid;
    acc_split = misaligned && !invalid;
`else
    acc_err   = invalid || misaligned;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = acc_err ? StResp : StReq0;
      StReq0:  if (mem_gnt) state_d = !we_q ? StWait0 : (split ? StReq1 : StResp);
      StWait0: if (mem_rvalid) state_d = split ? StReq1 : StResp;
`ifdef LSU_MISALIGN_SPLIT_EN
      StReq1:  if (mem_gnt) state_d = we_q ? StResp : StWait1;
      StWait1: if (mem_rvalid) state_d = StResp;
`endif
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture the request at accept and read beats as they return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      func3_q <= 3'b000;
      off_q   <= 2'd0;
      word_q  <= '0;
      be_q    <= 8'h00;
      wdata_q <= 64'h0;
      err_q   <= 1'b0;
      data0_q <= 32'h0;
      data1_q <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q    <= req_we;
        func3_q <= req_func3;
        off_q   <= off;
        word_q  <= req_addr[ADDR_W-1:2];
        be_q    <= {4'b0000, mask} << off;
        wdata_q <= {32'h0, req_wdata} << {off, 3'b000};
        err_q   <= acc_err;
        data0_q <= 32'h0;
        data1_q <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_q <= acc_split;
`endif
      end
      if ((state_q == StWait0) && mem_rvalid) data0_q <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      if ((state_q == StWait1) && mem_rvalid) data1_q <= mem_rdata;
`endif
    end
  end

  ld_extend u_ld_extend (
    .beat_data ({data1_q, data0_q}),
    .offset    (off_q),
    .func3     (func3_q),
    .result    (ext_data)
  );

  // Memory-side and pipeline-side outputs; memory fields are zero when idle.
  always_comb begin
    mem_req   = (state_q == StReq0) || beat_hi;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (mem_req) begin
      mem_we    = we_q;
      // Second beat word address wraps naturally at the top of the space.
      mem_addr  = {word_q + (ADDR_W-2)'(beat_hi), 2'b00};
      mem_be    = beat_hi ? be_q[7:4] : be_q[3:0];
      mem_wdata = beat_hi ? wdata_q[63:32] : wdata_q[31:0];
    end
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? ext_data : 32'h0;
    stall     = ((state_q != StIdle) && (state_q != StResp)) ||
                ((state_q == StIdle) && req_valid);
  end

endmodule
